// File: rtl/key_decoder.sv
// key_decoder: turns the raw per-cycle stdin byte stream into registered game
// events (flap, pause toggle, quit). Parses ESC [ A as an up-arrow flap and
// reports a lone or unrecognised ESC as quit.
module key_decoder #(
    parameter int unsigned FLAP_HOLD   = 5,
    parameter int unsigned ESC_TIMEOUT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  inp,
    output logic        flap_pulse,
    output logic        flapping,
    output logic        paused,
    output logic        quit,
    output logic [15:0] flap_count
);

    localparam int unsigned HW = $clog2(FLAP_HOLD + 1);
    localparam int unsigned TW = $clog2(ESC_TIMEOUT + 1);

    localparam logic [HW-1:0] HOLD_LOAD = HW'(FLAP_HOLD);
    localparam logic [TW-1:0] TIMER_MAX = TW'(ESC_TIMEOUT);
    // Timer value at which one more empty cycle completes the timeout.
    localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StEsc,
        StCsi
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;

    logic valid;
    logic is_flap, is_pause, is_quit, is_esc, is_lbrack, is_up;
    logic timeout;
    logic flap_ev, pause_ev, quit_ev;
    logic flap_acc;

    // 8'h00 and 8'hFF (EOF) mean "nothing typed this cycle".
    assign valid     = (inp != 8'h00) && (inp != 8'hFF);
    assign is_flap   = (inp == 8'h20) || (inp == 8'h77);
    assign is_pause  = (inp == 8'h70);
    assign is_quit   = (inp == 8'h71);
    assign is_esc    = (inp == 8'h1B);
    assign is_lbrack = (inp == 8'h5B);
    assign is_up     = (inp == 8'h41);
    assign timeout   = !valid && (timer_q == TIMER_LAST);

    // Decoder state and escape timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next decoder state and timer; any valid byte clears the timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (valid && is_esc) state_d = StEsc;
            end
            StEsc: begin
                if (valid) begin
                    timer_d = '0;
                    if (is_lbrack)   state_d = StCsi;
                    else if (is_esc) state_d = StEsc;
                    else             state_d = StIdle;
                end else if (timeout) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCsi: begin
                if (valid) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timeout) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Events produced by this cycle's byte in the current decoder state.
    always_comb begin
        flap_ev  = 1'b0;
        pause_ev = 1'b0;
        quit_ev  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    flap_ev  = is_flap;
                    pause_ev = is_pause;
                    quit_ev  = is_quit;
                end
            end
            StEsc: begin
                if (valid) begin
                    if (is_esc) begin
                        quit_ev = 1'b1;
                    end else if (!is_lbrack) begin
                        // Unrecognised escape: quit, and the byte still counts as a key.
                        quit_ev  = 1'b1;
                        flap_ev  = is_flap;
                        pause_ev = is_pause;
                    end
                end else if (timeout) begin
                    quit_ev = 1'b1;
                end
            end
            StCsi: begin
                if (valid && is_up) flap_ev = 1'b1;
            end
            default: begin
                flap_ev = 1'b0;
            end
        endcase
    end

    // Flaps are dropped while paused; pause and quit always pass.
    assign flap_acc = flap_ev && !paused;

    // Hold counter: reload on an accepted flap, otherwise run down to zero.
    always_comb begin
        hold_d = hold_q;
        if (flap_acc)          hold_d = HOLD_LOAD;
        else if (hold_q != '0) hold_d = hold_q - 1'b1;
    end

    // Registered outputs and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flap_pulse <= 1'b0;
            flapping   <= 1'b0;
            paused     <= 1'b0;
            quit       <= 1'b0;
            flap_count <= 16'h0000;
            hold_q     <= '0;
        end else begin
            flap_pulse <= flap_acc;
            quit       <= quit_ev;
            paused     <= paused ^ pause_ev;
            hold_q     <= hold_d;
            flapping   <= (hold_d != '0);
            if (flap_acc && (flap_count != 16'hFFFF)) flap_count <= flap_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_key_decoder.sv
// Testbench for key_decoder: a hand-computed vector table, hand-written reset
// and saturation sequences, and random bytes against a behavioural model.
module tb_key_decoder;

    localparam int H = 5;
    localparam int T = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inp;
    logic        flap_pulse, flapping, paused, quit;
    logic [15:0] flap_count;

    key_decoder #(
        .FLAP_HOLD  (H),
        .ESC_TIMEOUT(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .flap_pulse(flap_pulse),
        .flapping  (flapping),
        .paused    (paused),
        .quit      (quit),
        .flap_count(flap_count)
    );

    always #5 clk = ~clk;

    wire [19:0] dut_outs = {flap_pulse, flapping, paused, quit, flap_count};

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got {pulse,flapping,paused,quit,count}=%h required %h",
                      name, got, exp);
    endtask

    // Behavioural model: pending escape prefix (0 none, 1 "ESC", 2 "ESC ["),
    // number of empty cycles since the prefix, and the tick of the last flap.
    int      prefix, empties, m_count;
    bit      m_paused, m_pulse, m_quit, have_flap;
    longint  tick, last_flap;

    function automatic void model_reset();
        prefix = 0; empties = 0; m_count = 0;
        m_paused = 0; m_pulse = 0; m_quit = 0; have_flap = 0;
        tick = 0; last_flap = 0;
    endfunction

    // {flap, pause, quit} for a byte read with no escape pending.
    function automatic logic [2:0] key_class(input logic [7:0] b);
        return {(b == 8'h20 || b == 8'h77), (b == 8'h70), (b == 8'h71)};
    endfunction

    function automatic void model_step(input logic [7:0] b);
        bit valid = (b != 8'h00) && (b != 8'hFF);
        logic [2:0] k;
        bit f = 0, p = 0, q = 0;
        tick++;
        if (valid) empties = 0;
        case (prefix)
            0: if (valid) begin
                if (b == 8'h1B) prefix = 1;
                else {f, p, q} = key_class(b);
            end
            1: if (valid) begin
                if (b == 8'h5B) prefix = 2;
                else if (b == 8'h1B) q = 1;
                else begin
                    k = key_class(b);
                    f = k[2]; p = k[1]; q = 1;
                    prefix = 0;
                end
            end else begin
                empties++;
                if (empties == T) begin q = 1; prefix = 0; empties = 0; end
            end
            default: if (valid) begin
                f = (b == 8'h41);
                prefix = 0;
            end else begin
                empties++;
                if (empties == T) begin prefix = 0; empties = 0; end
            end
        endcase
        m_pulse = f && !m_paused;
        if (m_pulse) begin
            if (m_count < 65535) m_count++;
            last_flap = tick;
            have_flap = 1;
        end
        if (p) m_paused = !m_paused;
        m_quit = q;
    endfunction

    function automatic logic [19:0] model_outs();
        bit fl = have_flap && ((tick - last_flap) < H);
        return {m_pulse, fl, m_paused, m_quit, 16'(m_count)};
    endfunction

    // Drive one byte for one cycle and compare just after the capturing edge.
    task automatic step(input logic [7:0] b, input string name);
        inp = b;
        @(posedge clk);
        model_step(b);
        #1;
        check(name, dut_outs, model_outs());
    endtask

    task automatic do_reset();
        inp = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0]  b;
        logic [19:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b, input bit pu, input bit fl, input bit pa,
                                input bit q, input int c);
        vec_t v;
        v.b   = b;
        v.exp = {pu, fl, pa, q, 16'(c)};
        return v;
    endfunction

    vec_t vecs[33];
    logic [7:0] picks[10];

    initial begin
        // byte, pulse, flapping, paused, quit, count after the edge
        vecs[0]  = mk(8'h20, 1, 1, 0, 0, 1);
        vecs[1]  = mk(8'h00, 0, 1, 0, 0, 1);
        vecs[2]  = mk(8'h00, 0, 1, 0, 0, 1);
        vecs[3]  = mk(8'h20, 1, 1, 0, 0, 2);
        vecs[4]  = mk(8'h00, 0, 1, 0, 0, 2);
        vecs[5]  = mk(8'h00, 0, 1, 0, 0, 2);
        vecs[6]  = mk(8'h00, 0, 1, 0, 0, 2);
        vecs[7]  = mk(8'h00, 0, 1, 0, 0, 2);
        vecs[8]  = mk(8'h00, 0, 0, 0, 0, 2);
        vecs[9]  = mk(8'h1B, 0, 0, 0, 0, 2);
        vecs[10] = mk(8'h5B, 0, 0, 0, 0, 2);
        vecs[11] = mk(8'h41, 1, 1, 0, 0, 3);
        vecs[12] = mk(8'h1B, 0, 1, 0, 0, 3);
        vecs[13] = mk(8'h5B, 0, 1, 0, 0, 3);
        vecs[14] = mk(8'h42, 0, 1, 0, 0, 3);
        vecs[15] = mk(8'h1B, 0, 1, 0, 0, 3);
        vecs[16] = mk(8'h00, 0, 0, 0, 0, 3);
        vecs[17] = mk(8'hFF, 0, 0, 0, 0, 3);
        vecs[18] = mk(8'h00, 0, 0, 0, 1, 3);
        vecs[19] = mk(8'h00, 0, 0, 0, 0, 3);
        vecs[20] = mk(8'h1B, 0, 0, 0, 0, 3);
        vecs[21] = mk(8'h70, 0, 0, 1, 1, 3);
        vecs[22] = mk(8'h20, 0, 0, 1, 0, 3);
        vecs[23] = mk(8'h70, 0, 0, 0, 0, 3);
        vecs[24] = mk(8'h77, 1, 1, 0, 0, 4);
        vecs[25] = mk(8'h71, 0, 1, 0, 1, 4);
        vecs[26] = mk(8'h1B, 0, 1, 0, 0, 4);
        vecs[27] = mk(8'h1B, 0, 1, 0, 1, 4);
        vecs[28] = mk(8'h5B, 0, 1, 0, 0, 4);
        vecs[29] = mk(8'h00, 0, 0, 0, 0, 4);
        vecs[30] = mk(8'h00, 0, 0, 0, 0, 4);
        vecs[31] = mk(8'h00, 0, 0, 0, 0, 4);
        vecs[32] = mk(8'h41, 0, 0, 0, 0, 4);

        picks = '{8'h00, 8'hFF, 8'h20, 8'h77, 8'h70, 8'h71, 8'h1B, 8'h5B, 8'h41, 8'h42};

        // Reset state
        rst = 1'b1;
        inp = 8'h00;
        #2;
        check("reset_state", dut_outs, 20'h0);
        do_reset();
        check("after_release", dut_outs, 20'h0);

        // Vector table
        for (int i = 0; i < 33; i++) begin
            inp = vecs[i].b;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_in%h", i, vecs[i].b), dut_outs, vecs[i].exp);
        end

        // Reset while in CSI with flapping high clears at once; a later 'A' is plain
        do_reset();
        step(8'h20, "rst_seq_flap");
        step(8'h1B, "rst_seq_esc");
        step(8'h5B, "rst_seq_csi");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clears", dut_outs, 20'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(8'h41, "after_reset_A");
        check("after_reset_A_no_flap", dut_outs, 20'h0);

        // Random bytes against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            int sel = $urandom_range(0, 12);
            if (sel < 10) b = picks[sel];
            else if (sel == 10) b = 8'h00;
            else b = 8'($urandom_range(0, 255));
            step(b, $sformatf("rand%0d_in%h", i, b));
        end

        // Saturate flap_count with back-to-back spaces
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            inp = 8'h20;
            @(posedge clk);
            model_step(8'h20);
        end
        #1;
        check("count_reaches_ffff", dut_outs, model_outs());
        check("count_is_ffff", {4'h0, flap_count}, 20'h0FFFF);
        step(8'h20, "sat_flap1");
        step(8'h77, "sat_flap2");
        check("count_stays_ffff", {4'h0, flap_count}, 20'h0FFFF);
        step(8'h00, "sat_idle");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
